// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared types and sizing for the AES-256 key-schedule controller and its round-key store.
package aes256_key_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int NRK      = 15;
    localparam int RCW      = 4;
    localparam int RK_W     = 128;
    localparam int KEY_W    = 256;
    localparam int RK_IDX_W = 4;
    // Last round-constant index; one 256-bit window is produced per index.
    localparam int RC_LAST  = 7;

endpackage

// File: rtl/aes256_key_sched_ctrl_rk_store.sv
// Round-key storage: NRK x 128-bit entries, one paired (even/odd) write port, one registered read port.
module aes256_rk_store #(
    parameter int NRK   = aes256_key_sched_ctrl_pkg::NRK,
    parameter int IDX_W = aes256_key_sched_ctrl_pkg::RK_IDX_W,
    parameter int RK_W  = aes256_key_sched_ctrl_pkg::RK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [RK_W-1:0]  wr_hi,
    input  logic [RK_W-1:0]  wr_lo,
    input  logic             wr_lo_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_allow,
    output logic [RK_W-1:0]  rd_data
);

    logic [RK_W-1:0]  mem_view [NRK];
    logic [IDX_W-1:0] lo_idx;
    logic [RK_W-1:0]  rd_data_q, rd_data_d;

    assign lo_idx = wr_idx + IDX_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NRK; gi++) begin : g_entry
            logic [RK_W-1:0] ent_q, ent_d;

            always_comb begin
                ent_d = ent_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ent_d = wr_hi;
                end else if (wr_en && wr_lo_en && (lo_idx == IDX_W'(gi))) begin
                    ent_d = wr_lo;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ent_q <= '0;
                end else begin
                    ent_q <= ent_d;
                end
            end

            assign mem_view[gi] = ent_q;
        end
    endgenerate

    // Out-of-range or disallowed reads return zero rather than stale contents.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_allow && (32'(rd_idx) < NRK)) begin
                rd_data_d = mem_view[rd_idx];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-schedule controller: sequences an external expansion datapath and stores rk0..rk14.
module aes256_key_sched_ctrl #(
    parameter int NRK = aes256_key_sched_ctrl_pkg::NRK,
    parameter int RCW = aes256_key_sched_ctrl_pkg::RCW
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       key_valid,
    output logic                                       key_ready,
    input  logic [aes256_key_sched_ctrl_pkg::KEY_W-1:0] key_in,
    output logic [RCW-1:0]                             exp_rc,
    output logic [aes256_key_sched_ctrl_pkg::KEY_W-1:0] exp_key,
    input  logic [aes256_key_sched_ctrl_pkg::KEY_W-1:0] exp_keyout,
    input  logic                                       rk_rd_en,
    input  logic [3:0]                                 rk_rd_idx,
    output logic [aes256_key_sched_ctrl_pkg::RK_W-1:0]  rk_rd_data,
    output logic                                       keys_valid,
    output logic                                       busy
);

    import aes256_key_sched_ctrl_pkg::*;

    state_e              state_q, state_d;
    logic [RCW-1:0]      rc_q, rc_d;
    logic [KEY_W-1:0]    win_q, win_d;
    logic                kv_q, kv_d;

    logic                wr_en;
    logic [RK_IDX_W-1:0] wr_idx;
    logic [RK_W-1:0]     wr_hi;
    logic [RK_W-1:0]     wr_lo;
    logic                wr_lo_en;
    logic                accept;
    logic                rd_allow;

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        win_d     = win_q;
        kv_d      = kv_q;
        key_ready = 1'b0;
        busy      = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_hi     = '0;
        wr_lo     = '0;
        wr_lo_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_d  = ST_EXPAND;
                    rc_d     = RCW'(1);
                    win_d    = key_in;
                    kv_d     = 1'b0;
                    wr_en    = 1'b1;
                    wr_idx   = '0;
                    wr_hi    = key_in[KEY_W-1:RK_W];
                    wr_lo    = key_in[RK_W-1:0];
                    wr_lo_en = 1'b1;
                end
            end
            ST_EXPAND: begin
                busy     = 1'b1;
                win_d    = exp_keyout;
                wr_en    = 1'b1;
                wr_idx   = RK_IDX_W'({rc_q, 1'b0});
                wr_hi    = exp_keyout[KEY_W-1:RK_W];
                wr_lo    = exp_keyout[RK_W-1:0];
                // The final window only yields rk14; its low half has no slot.
                wr_lo_en = (rc_q != RCW'(RC_LAST));
                if (rc_q == RCW'(RC_LAST)) begin
                    state_d = ST_DONE;
                    rc_d    = '0;
                    kv_d    = 1'b1;
                end else begin
                    rc_d    = rc_q + RCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            win_q   <= '0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            win_q   <= win_d;
            kv_q    <= kv_d;
        end
    end

    // A read coinciding with a rekey sees keys as already invalidated.
    assign accept   = key_valid && key_ready;
    assign rd_allow = kv_q && !accept;

    aes256_rk_store #(
        .NRK   (NRK),
        .IDX_W (RK_IDX_W),
        .RK_W  (RK_W)
    ) u_rk_store (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_lo_en (wr_lo_en),
        .rd_en    (rk_rd_en),
        .rd_idx   (rk_rd_idx),
        .rd_allow (rd_allow),
        .rd_data  (rk_rd_data)
    );

    assign exp_rc     = rc_q;
    assign exp_key    = win_q;
    assign keys_valid = kv_q;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: behavioural AES-256 expansion model plus read scoreboard.
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic [3:0]   exp_rc;
    logic [255:0] exp_key;
    logic [255:0] exp_keyout;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         keys_valid;
    logic         busy;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] sb_q [$];
    logic [127:0] model_rk [15];

    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes256_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .exp_rc     (exp_rc),
        .exp_key    (exp_key),
        .exp_keyout (exp_keyout),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    // ---------------- AES-256 key expansion model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [255:0] model_next(input logic [255:0] win, input logic [3:0] rc);
        logic [31:0] w [8];
        logic [31:0] n [8];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) w[i] = win[255-32*i -: 32];
        rcon = (rc == 4'd0) ? 8'h00 : (8'h01 << (rc - 4'd1));
        t    = subword({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        n[0] = w[0] ^ t;
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        n[4] = w[4] ^ subword(n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    // The external datapath is stood in for by the model.
    assign exp_keyout = model_next(exp_key, exp_rc);

    task automatic build_model(input logic [255:0] key);
        logic [255:0] w = key;
        model_rk[0] = key[255:128];
        model_rk[1] = key[127:0];
        for (int rc = 1; rc <= 7; rc++) begin
            w = model_next(w, 4'(rc));
            model_rk[2*rc] = w[255:128];
            if (rc < 7) model_rk[2*rc+1] = w[127:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_rd_en = 1'b0; rk_rd_idx = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({key_ready, busy, keys_valid, exp_rc} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b kv=%b rc=%0d want rdy=1 busy=0 kv=0 rc=0",
                     key_ready, busy, keys_valid, exp_rc);
        end
        checks++;
        if (exp_key !== 256'h0) begin
            failures++;
            $display("FAIL reset_exp_key got=%h want=0", exp_key);
        end
        checks++;
        if (rk_rd_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_rd_data got=%h want=0", rk_rd_data);
        end
        $display("txn reset done");
    endtask

    task automatic test_expand(input logic [255:0] key);
        logic [255:0] win = key;
        logic [255:0] prev_out = '0;
        build_model(key);
        key_valid = 1'b1; key_in = key;
        tick();
        key_valid = 1'b0;
        for (int rc = 1; rc <= 7; rc++) begin
            checks++;
            if ({busy, key_ready, keys_valid, exp_rc} !== {1'b1, 1'b0, 1'b0, 4'(rc)}) begin
                failures++;
                $display("FAIL expand_ctrl cyc=%0d got busy=%b rdy=%b kv=%b rc=%0d want busy=1 rdy=0 kv=0 rc=%0d",
                         rc, busy, key_ready, keys_valid, exp_rc, rc);
            end
            checks++;
            if (exp_key !== win) begin
                failures++;
                $display("FAIL expand_window cyc=%0d got=%h want=%h", rc, exp_key, win);
            end
            if (rc > 1) begin
                checks++;
                if (exp_key !== prev_out) begin
                    failures++;
                    $display("FAIL window_follows_keyout cyc=%0d got=%h want=%h", rc, exp_key, prev_out);
                end
            end
            prev_out = exp_keyout;
            win = model_next(win, 4'(rc));
            tick();
        end
        // Accepting edge plus seven expansion edges: eighth edge raises keys_valid.
        checks++;
        if ({keys_valid, busy, key_ready, exp_rc} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL kv_latency got kv=%b busy=%b rdy=%b rc=%0d want kv=1 busy=0 rdy=1 rc=0",
                     keys_valid, busy, key_ready, exp_rc);
        end
        $display("txn expand key=%h done", key);
    endtask

    task automatic test_known_vectors();
        logic [3:0]   idx_tab [4] = '{4'd2, 4'd14, 4'd0, 4'd1};
        logic [127:0] val_tab [4] = '{128'ha573c29fa176c498a97fce93a572c09c,
                                      128'h24fc79ccbf0979e9371ac23c6d68de36,
                                      128'h000102030405060708090a0b0c0d0e0f,
                                      128'h101112131415161718191a1b1c1d1e1f};
        logic [127:0] want;
        for (int i = 0; i < 4; i++) begin
            rk_rd_en = 1'b1; rk_rd_idx = idx_tab[i];
            sb_q.push_back(val_tab[i]);
            tick();
            want = sb_q.pop_front();
            checks++;
            if (rk_rd_data !== want) begin
                failures++;
                $display("FAIL known_vector idx=%0d got=%h want=%h", idx_tab[i], rk_rd_data, want);
            end
            $display("txn read idx=%0d data=%h", idx_tab[i], rk_rd_data);
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_read_all();
        logic [127:0] want;
        logic [127:0] last = '0;
        for (int i = 0; i <= 15; i++) begin
            rk_rd_en = 1'b1; rk_rd_idx = 4'(i);
            sb_q.push_back((i < 15) ? model_rk[i] : 128'h0);
            tick();
            want = sb_q.pop_front();
            last = want;
            checks++;
            if (rk_rd_data !== want) begin
                failures++;
                $display("FAIL read_all idx=%0d got=%h want=%h", i, rk_rd_data, want);
            end
            $display("txn read idx=%0d data=%h", i, rk_rd_data);
        end
        // Read 5, then idle with a different index: data must hold.
        rk_rd_idx = 4'd5; sb_q.push_back(model_rk[5]);
        tick();
        last = sb_q.pop_front();
        rk_rd_en = 1'b0; rk_rd_idx = 4'd9;
        tick(); tick();
        checks++;
        if (rk_rd_data !== last) begin
            failures++;
            $display("FAIL read_hold got=%h want=%h", rk_rd_data, last);
        end
        $display("txn read_hold data=%h", rk_rd_data);
    endtask

    task automatic test_read_busy();
        logic [255:0] key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        logic [127:0] want;
        build_model(key);
        key_valid = 1'b1; key_in = key;
        tick();
        key_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rk_rd_en = 1'b1; rk_rd_idx = 4'($urandom_range(0, 14));
            sb_q.push_back(128'h0);
            tick();
            want = sb_q.pop_front();
            checks++;
            if (rk_rd_data !== want) begin
                failures++;
                $display("FAIL read_busy cyc=%0d got=%h want=%h", c, rk_rd_data, want);
            end
        end
        for (int i = 3; i < 15; i += 5) begin
            rk_rd_idx = 4'(i); sb_q.push_back(model_rk[i]);
            tick();
            want = sb_q.pop_front();
            checks++;
            if (rk_rd_data !== want) begin
                failures++;
                $display("FAIL read_after_busy idx=%0d got=%h want=%h", i, rk_rd_data, want);
            end
            $display("txn read idx=%0d data=%h", i, rk_rd_data);
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_hold_and_rekey();
        logic [255:0] k2 = {8{32'hdeadbeef}} ^ KEY_A;
        logic [255:0] k3 = ~KEY_A;
        logic [127:0] want;
        int           n;
        key_valid = 1'b1; key_in = k2;
        tick();
        for (int rc = 1; rc <= 7; rc++) begin
            checks++;
            if ({exp_rc, key_ready} !== {4'(rc), 1'b0}) begin
                failures++;
                $display("FAIL hold_not_accepted cyc=%0d got rc=%0d rdy=%b want rc=%0d rdy=0",
                         rc, exp_rc, key_ready, rc);
            end
            tick();
        end
        // Now in DONE with key_valid still high: this edge rekeys with k3.
        key_in = k3;
        rk_rd_en = 1'b1; rk_rd_idx = 4'd0;
        sb_q.push_back(128'h0);
        tick();
        key_valid = 1'b0; rk_rd_en = 1'b0;
        want = sb_q.pop_front();
        checks++;
        if (rk_rd_data !== want) begin
            failures++;
            $display("FAIL read_on_rekey got=%h want=%h", rk_rd_data, want);
        end
        checks++;
        if ({keys_valid, busy, exp_rc} !== {1'b0, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL rekey_drop got kv=%b busy=%b rc=%0d want kv=0 busy=1 rc=1",
                     keys_valid, busy, exp_rc);
        end
        n = 0;
        while (!keys_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL rekey_latency got=%0d edges after accept want=7", n);
        end
        build_model(k3);
        rk_rd_en = 1'b1; rk_rd_idx = 4'd2; sb_q.push_back(model_rk[2]);
        tick();
        rk_rd_en = 1'b0;
        want = sb_q.pop_front();
        checks++;
        if (rk_rd_data !== want) begin
            failures++;
            $display("FAIL rekey_read idx=2 got=%h want=%h", rk_rd_data, want);
        end
        $display("txn rekey key=%h latency=%0d", k3, n);
    endtask

    task automatic test_reset_mid();
        logic [127:0] want;
        int           pulses = 0;
        key_valid = 1'b1; key_in = KEY_A;
        tick();
        key_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (exp_rc !== 4'd4) begin
            failures++;
            $display("FAIL mid_rc got=%0d want=4", exp_rc);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, keys_valid, key_ready, exp_rc} !== {1'b0, 1'b0, 1'b1, 4'd0} || exp_key !== 256'h0) begin
            failures++;
            $display("FAIL mid_reset_async got busy=%b kv=%b rdy=%b rc=%0d key=%h want busy=0 kv=0 rdy=1 rc=0 key=0",
                     busy, keys_valid, key_ready, exp_rc, exp_key);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (keys_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL mid_no_kv_pulse got=%0d want=0", pulses);
        end
        rk_rd_en = 1'b1; rk_rd_idx = 4'd2; sb_q.push_back(128'h0);
        tick();
        rk_rd_en = 1'b0;
        want = sb_q.pop_front();
        checks++;
        if (rk_rd_data !== want) begin
            failures++;
            $display("FAIL mid_read idx=2 got=%h want=%h", rk_rd_data, want);
        end
        $display("txn reset_mid done");
    endtask

    initial begin
        test_reset();
        test_expand(KEY_A);
        test_known_vectors();
        test_read_all();
        test_read_busy();
        test_hold_and_rekey();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
